// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Main sequencing FSM for the multicycle fibcore datapath.
//            Optional macro PERF_CNT_EN adds cycle_cnt/instret_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  imm_src,
  output logic        retire,
  output logic        trap,
  output logic        bus_err
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_alur   = 7'b0110011;
  localparam logic [6:0] c_op_alui   = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  localparam int c_cnt_w = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  // Compare against the pre-increment count: the cycle the count would reach the limit.
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXER   = 4'd7,
    S_EXEI   = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JAL    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_req = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      S_DECODE: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEMADR: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEMRD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      S_MEMWB:  begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEMWR:  begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.adr_src = 1'b1; end
      S_EXER:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXEI:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:  c.reg_write = 1'b1;
      S_BRANCH: begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; end
      S_JAL:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_t             r_state;
  state_t             w_next;
  ctrl_t              r_ctrl;
  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_trap;
  logic               r_bus_err;
  logic               w_mem_state;
  logic               w_timeout;
  logic               w_retire;

  always_comb begin
    w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    w_timeout   = (MEM_TIMEOUT != 0) && w_mem_state && !mem_ready && (r_wait_cnt == c_limit);
    w_next      = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
      S_DECODE: begin
        if ((opcode == c_op_load) || (opcode == c_op_store)) w_next = S_MEMADR;
        else if (opcode == c_op_alur) w_next = S_EXER;
        else if (opcode == c_op_alui) w_next = S_EXEI;
        else if ((opcode == c_op_branch) && (funct3[2:1] == 2'b00)) w_next = S_BRANCH;
        else if (opcode == c_op_jal) w_next = S_JAL;
        else w_next = S_TRAP;
      end
      S_MEMADR: w_next = (opcode == c_op_store) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
                else if (w_timeout) w_next = S_TRAP;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH;
                else if (w_timeout) w_next = S_TRAP;
      S_EXER:   w_next = S_ALUWB;
      S_EXEI:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JAL:    w_next = S_ALUWB;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_TRAP;
    endcase
  end

  // Registered strobes are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_ctrl      <= '0;
      r_wait_cnt  <= '0;
      r_trap      <= 1'b0;
      r_bus_err   <= 1'b0;
`ifdef PERF_CNT_EN
      cycle_cnt   <= '0;
      instret_cnt <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode_ctrl(w_next);
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (w_mem_state && !mem_ready)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_next == S_TRAP) r_trap <= 1'b1;
      if (w_timeout) r_bus_err <= 1'b1;
`ifdef PERF_CNT_EN
      if (r_state != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (w_retire) instret_cnt <= instret_cnt + 32'd1;
`endif
    end
  end

  always_comb begin
    imm_src = 2'b00;
    if (r_state == S_DECODE)
      imm_src = (opcode == c_op_jal) ? 2'b11 : 2'b10;
    else if ((r_state == S_MEMADR) && (opcode == c_op_store))
      imm_src = 2'b01;
  end

  assign w_retire   = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BRANCH) ||
                      ((r_state == S_MEMWR) && mem_ready);
  assign ir_write   = (r_state == S_FETCH) && mem_ready;
  assign pc_write   = ((r_state == S_FETCH) && mem_ready) || (r_state == S_JAL) ||
                      ((r_state == S_BRANCH) && (funct3[0] ? !zero : zero));
  assign retire     = w_retire;
  assign mem_req    = r_ctrl.mem_req;
  assign mem_we     = r_ctrl.mem_we;
  assign adr_src    = r_ctrl.adr_src;
  assign reg_write  = r_ctrl.reg_write;
  assign result_src = r_ctrl.result_src;
  assign alu_src_a  = r_ctrl.alu_src_a;
  assign alu_src_b  = r_ctrl.alu_src_b;
  assign alu_op     = r_ctrl.alu_op;
  assign trap       = r_trap;
  assign bus_err    = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic        retire, trap, bus_err;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_src(imm_src), .retire(retire), .trap(trap), .bus_err(bus_err)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  // Field order: req we adr irw pcw rw rs[2] sa[2] sb[2] op[2] imm[2] ret trap be
  logic [18:0] obs;
  assign obs = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_op, imm_src, retire, trap, bus_err};

  function automatic logic [18:0] mk(input logic req, input logic we, input logic adr,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] op,
                                      input logic [1:0] imm, input logic ret,
                                      input logic trp, input logic be);
    return {req, we, adr, irw, pcw, rw, rs, sa, sb, op, imm, ret, trp, be};
  endfunction

  localparam logic [18:0] V_IDLE    = 19'd0;
  localparam logic [18:0] V_F_RDY   = mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0);
  localparam logic [18:0] V_F_WAIT  = mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0);
  localparam logic [18:0] V_DEC     = mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0,0,0);
  localparam logic [18:0] V_DEC_J   = mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b11,0,0,0);
  localparam logic [18:0] V_EXER    = mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,2'b00,0,0,0);
  localparam logic [18:0] V_EXEI    = mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,2'b00,0,0,0);
  localparam logic [18:0] V_ALUWB   = mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,1,0,0);
  localparam logic [18:0] V_MA_LW   = mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,0,0,0);
  localparam logic [18:0] V_MA_SW   = mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b01,0,0,0);
  localparam logic [18:0] V_MRD     = mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0);
  localparam logic [18:0] V_MWB     = mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,2'b00,1,0,0);
  localparam logic [18:0] V_MWR_W   = mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0);
  localparam logic [18:0] V_MWR_R   = mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,1,0,0);
  localparam logic [18:0] V_BR_T    = mk(0,0,0,0,1,0,2'b00,2'b10,2'b00,2'b01,2'b00,1,0,0);
  localparam logic [18:0] V_BR_N    = mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b00,1,0,0);
  localparam logic [18:0] V_JAL     = mk(0,0,0,0,1,0,2'b00,2'b01,2'b10,2'b00,2'b00,0,0,0);
  localparam logic [18:0] V_TRAP    = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,1,0);
  localparam logic [18:0] V_TRAP_BE = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,1,1);

  // Leaves the DUT in IDLE, just after a falling edge.
  task automatic do_reset();
    rstn = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; mem_ready = 1'b1; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (obs !== V_IDLE) begin n_fail++; $display("FAIL reset_hold obs=%h exp=%h", obs, V_IDLE); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_checks++;
    if (obs !== V_IDLE) begin n_fail++; $display("FAIL reset_idle obs=%h exp=%h", obs, V_IDLE); end
    @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (obs !== V_F_WAIT) begin n_fail++; $display("FAIL reset_fetch c%0d obs=%h exp=%h", i, obs, V_F_WAIT); end
      @(negedge clk);
    end
  endtask

  task automatic test_alu_r();
    logic [18:0] ev [4];
    ev = '{V_F_RDY, V_DEC, V_EXER, V_ALUWB};
    opcode = 7'b0110011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL alu_r c%0d obs=%h exp=%h", i, obs, ev[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_alu_i();
    logic [18:0] ev [4];
    ev = '{V_F_RDY, V_DEC, V_EXEI, V_ALUWB};
    opcode = 7'b0010011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL alu_i c%0d obs=%h exp=%h", i, obs, ev[i]); end
      @(negedge clk);
    end
  endtask

  // Three wait cycles put the ready cycle exactly on the timeout boundary.
  task automatic test_lw_wait();
    logic [18:0] ev [8];
    logic        rdy [8];
    ev  = '{V_F_RDY, V_DEC, V_MA_LW, V_MRD, V_MRD, V_MRD, V_MRD, V_MWB};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 7'b0000011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #1;
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL lw_wait c%0d obs=%h exp=%h", i, obs, ev[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    logic [18:0] ev [5];
    logic        rdy [5];
    ev  = '{V_F_RDY, V_DEC, V_MA_SW, V_MWR_W, V_MWR_R};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    opcode = 7'b0100011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      #1;
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL sw c%0d obs=%h exp=%h", i, obs, ev[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3  [4];
    logic        z   [4];
    logic [18:0] ebr [4];
    f3  = '{3'b000, 3'b001, 3'b000, 3'b001};
    z   = '{1'b1, 1'b1, 1'b0, 1'b0};
    ebr = '{V_BR_T, V_BR_N, V_BR_N, V_BR_T};
    opcode = 7'b1100011;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      funct3 = f3[k];
      zero   = z[k];
      #1;
      n_checks++;
      if (obs !== V_F_RDY) begin n_fail++; $display("FAIL branch%0d_fetch obs=%h exp=%h", k, obs, V_F_RDY); end
      @(negedge clk);
      #1;
      n_checks++;
      if (obs !== V_DEC) begin n_fail++; $display("FAIL branch%0d_dec obs=%h exp=%h", k, obs, V_DEC); end
      @(negedge clk);
      #1;
      n_checks++;
      if (obs !== ebr[k]) begin n_fail++; $display("FAIL branch%0d_exe obs=%h exp=%h", k, obs, ebr[k]); end
      @(negedge clk);
    end
    funct3 = 3'd0;
    zero   = 1'b0;
  endtask

  task automatic test_jal();
    logic [18:0] ev [4];
    ev = '{V_F_RDY, V_DEC_J, V_JAL, V_ALUWB};
    opcode = 7'b1101111;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL jal c%0d obs=%h exp=%h", i, obs, ev[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midop();
    logic [18:0] ev [4];
    logic        rdy [4];
    ev  = '{V_F_RDY, V_DEC, V_MA_LW, V_MRD};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
    opcode = 7'b0000011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = rdy[i];
      #1;
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL midop c%0d obs=%h exp=%h", i, obs, ev[i]); end
      if (i < 3) @(negedge clk);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (obs !== V_IDLE) begin n_fail++; $display("FAIL midop_async obs=%h exp=%h", obs, V_IDLE); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_checks++;
    if (obs !== V_IDLE) begin n_fail++; $display("FAIL midop_idle obs=%h exp=%h", obs, V_IDLE); end
    @(negedge clk);
    #1;
    n_checks++;
    if (obs !== V_F_WAIT) begin n_fail++; $display("FAIL midop_fetch obs=%h exp=%h", obs, V_F_WAIT); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [18:0] ev [5];
`ifdef PERF_CNT_EN
    logic [31:0] inst_snap;
    logic [31:0] cyc_snap;
`endif
    ev = '{V_F_RDY, V_DEC, V_TRAP, V_TRAP, V_TRAP};
    opcode = 7'b0000000;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL illegal c%0d obs=%h exp=%h", i, obs, ev[i]); end
`ifdef PERF_CNT_EN
      if (i == 2) begin inst_snap = instret_cnt; cyc_snap = cycle_cnt; end
`endif
      @(negedge clk);
    end
`ifdef PERF_CNT_EN
    n_checks++;
    if (instret_cnt !== inst_snap) begin n_fail++; $display("FAIL perf_instret obs=%0d exp=%0d", instret_cnt, inst_snap); end
    n_checks++;
    if (cycle_cnt !== cyc_snap) begin n_fail++; $display("FAIL perf_cycle obs=%0d exp=%0d", cycle_cnt, cyc_snap); end
`endif
  endtask

  task automatic test_illegal_branch();
    logic [18:0] ev [3];
    ev = '{V_F_RDY, V_DEC, V_TRAP};
    do_reset();
    @(negedge clk);
    opcode = 7'b1100011;
    funct3 = 3'b010;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL bad_branch c%0d obs=%h exp=%h", i, obs, ev[i]); end
      @(negedge clk);
    end
    funct3 = 3'd0;
  endtask

  task automatic test_timeout();
    logic [18:0] ev [6];
    logic        rdy [6];
    ev  = '{V_F_WAIT, V_F_WAIT, V_F_WAIT, V_F_WAIT, V_TRAP_BE, V_TRAP_BE};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    @(negedge clk);
    opcode = 7'b0110011;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy[i];
      #1;
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL timeout c%0d obs=%h exp=%h", i, obs, ev[i]); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_alu_r();
    test_alu_i();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jal();
    test_reset_midop();
    test_illegal();
    test_illegal_branch();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
